// File: rtl/gf257_pkg.sv
// gf257_pkg: shared constants and FSM encoding for the GF(2^257) inverter
// Field polynomial x^257 + x^12 + 1; Itoh-Tsujii runs ITOH_ROUNDS multiply rounds.
package gf257_pkg;
  localparam int DW = 257;
  localparam int TAP = 12;
  localparam int ITOH_ROUNDS = 8;
  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    FIN_ISSUE,
    FIN_WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/mod_multiplier.sv
// mod_multiplier: digit-serial GF(2^257) multiplier, 64 bits of b per cycle
// Ports: clk, rst (async active-low), start (one-cycle load pulse), a/b operands,
//        res (product, valid with finish), finish (one-cycle done pulse).
// A start while running restarts the multiplier with the new operands.
module mod_multiplier
  import gf257_pkg::*;
#(
  parameter int DW = gf257_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res,
  output logic          finish
);
  localparam int DG = 64;
  localparam int NG = (DW + DG - 1) / DG;
  localparam int BW = NG * DG;
  localparam logic [DW-1:0] RED = (DW'(1) << TAP) | DW'(1);
  logic [DW-1:0] a_r, acc_n;
  logic [BW-1:0] b_r;
  logic [3:0] cnt;
  // b is zero-extended at the top so leading digits leave the accumulator at 0
  always_comb begin
    acc_n = res;
    for (int i = 0; i < DG; i++)
      acc_n = {acc_n[DW-2:0], 1'b0} ^ (acc_n[DW-1] ? RED : '0) ^ (b_r[BW-1-i] ? a_r : '0);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= '0;
      b_r <= '0;
      res <= '0;
      cnt <= '0;
      finish <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (start) begin
        a_r <= a;
        b_r <= BW'(b);
        res <= '0;
        cnt <= 4'(NG);
      end else if (cnt != 4'd0) begin
        res <= acc_n;
        b_r <= b_r << DG;
        cnt <= cnt - 4'd1;
        finish <= (cnt == 4'd1);
      end
    end
  end
endmodule

// File: rtl/gf_inverter.sv
// gf_inverter: Itoh-Tsujii inversion in GF(2^257) over one shared multiplier
// Ports: clk, rst (async active-low), start (level: load A / abort), A (operand),
//        res (A^-1, valid with finish), finish (done_r & !start), busy (computing),
//        zero_err (only with GF_INV_ZERO_FLAG_EN: captured A was zero).
module gf_inverter
  import gf257_pkg::*;
#(
  parameter int DW = gf257_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] A,
  output logic [DW-1:0] res,
  output logic          finish,
  output logic          busy
`ifdef GF_INV_ZERO_FLAG_EN
  ,
  output logic          zero_err
`endif
);
  state_t state, state_n;
  logic [DW-1:0] beta, t, sub_a, sub_b, sub_res;
  logic [7:0] k, sq_rem;
  logic done_r, sub_start, sub_finish, skip, got;
  // skip masks sub_finish in the cycle after an issue (possible stale pulse)
  assign got = sub_finish && !skip;
  assign finish = done_r && !start;
  assign busy = !(state inside {IDLE, LOAD, DONE});
  always_comb begin
    state_n = state;
    sub_start = 1'b0;
    sub_a = t;
    sub_b = t;
    if (start) state_n = LOAD;
    else case (state)
      LOAD: state_n = SQ_ISSUE;
      SQ_ISSUE: begin
        sub_start = 1'b1;
        state_n = SQ_WAIT;
      end
      SQ_WAIT: if (got) state_n = (sq_rem == 8'd1) ? MUL_ISSUE : SQ_ISSUE;
      MUL_ISSUE: begin
        sub_start = 1'b1;
        sub_b = beta;
        state_n = MUL_WAIT;
      end
      MUL_WAIT: if (got) state_n = k[ITOH_ROUNDS-1] ? FIN_ISSUE : SQ_ISSUE;
      FIN_ISSUE: begin
        sub_start = 1'b1;
        sub_a = beta;
        sub_b = beta;
        state_n = FIN_WAIT;
      end
      FIN_WAIT: if (got) state_n = DONE;
      default: ;
    endcase
  end
  // t walks beta_k through its k squarings; the round product becomes beta_2k
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beta <= '0;
      t <= '0;
      res <= '0;
      k <= '0;
      sq_rem <= '0;
      done_r <= 1'b0;
      skip <= 1'b0;
    end else begin
      state <= state_n;
      skip <= sub_start;
      if (start) begin
        beta <= A;
        t <= A;
        k <= 8'd1;
        sq_rem <= 8'd1;
        done_r <= 1'b0;
      end else if (got) begin
        case (state)
          SQ_WAIT: begin
            t <= sub_res;
            sq_rem <= sq_rem - 8'd1;
          end
          MUL_WAIT: begin
            beta <= sub_res;
            t <= sub_res;
            k <= k << 1;
            sq_rem <= k << 1;
          end
          FIN_WAIT: begin
            res <= sub_res;
            done_r <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
`ifdef GF_INV_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) zero_err <= 1'b0;
    else if (start) zero_err <= (A == '0);
  end
`endif
  mod_multiplier #(.DW(DW)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(sub_start),
    .a(sub_a),
    .b(sub_b),
    .res(sub_res),
    .finish(sub_finish)
  );
endmodule

// File: tb/tb_gf_inverter.sv
// tb_gf_inverter: scoreboard bench for gf_inverter against a Fermat-inversion model
module tb_gf_inverter;
  import gf257_pkg::*;
  localparam int W = 257;
  localparam int LAT_MAX = 11000;
  localparam logic [W-1:0] RED = (W'(1) << 12) | W'(1);
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] res;
  logic finish, busy;
`ifdef GF_INV_ZERO_FLAG_EN
  logic zero_err;
`endif
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] a_q[$];
  gf_inverter dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .res(res),
    .finish(finish),
    .busy(busy)
`ifdef GF_INV_ZERO_FLAG_EN
    ,
    .zero_err(zero_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] gmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r = '0;
    logic [W-1:0] xx = x;
    for (int i = 0; i < W; i++) begin
      if (y[i]) r ^= xx;
      xx = {xx[W-2:0], 1'b0} ^ (xx[W-1] ? RED : '0);
    end
    return r;
  endfunction
  function automatic logic [W-1:0] ginv(input logic [W-1:0] x);
    logic [W-1:0] s = x;
    logic [W-1:0] r = W'(1);
    for (int i = 1; i < W; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [W-1:0] rand_elem();
    logic [W-1:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[W-33:0], 32'($urandom)};
    return (v == '0) ? W'(1) : v;
  endfunction
  task automatic issue(input logic [W-1:0] a);
    @(negedge clk);
    A = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic start_inv(input logic [W-1:0] a);
    exp_q.push_back(ginv(a));
    a_q.push_back(a);
    issue(a);
  endtask
  task automatic collect(input string tag);
    int n = 0;
    logic [W-1:0] e, a;
    while (!finish && n < LAT_MAX) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, W'(finish), W'(1));
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, W'(exp_q.size()), W'(1));
      return;
    end
    e = exp_q.pop_front();
    a = a_q.pop_front();
    chk(tag, res, e);
    if (a != '0) chk({tag, "_prod"}, gmul(res, a), W'(1));
    chk({tag, "_busy"}, W'(busy), W'(0));
  endtask
  initial begin
    logic [W-1:0] x_inv;
    int n;
    x_inv = (W'(1) << 256) | (W'(1) << 11);
    repeat (3) @(negedge clk);
    chk("rst_res", res, '0);
    chk("rst_finish", W'(finish), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    rst = 1'b1;
    start_inv(W'(1));
    collect("inv_one");
    start_inv(W'(2));
    collect("inv_x");
    chk("inv_x_const", res, x_inv);
    start_inv('0);
    collect("inv_zero");
`ifdef GF_INV_ZERO_FLAG_EN
    chk("zero_err_set", W'(zero_err), W'(1));
`endif
    issue(rand_elem());
    repeat (300) @(negedge clk);
    chk("mid_busy", W'(busy), W'(1));
    chk("mid_finish", W'(finish), W'(0));
    start_inv(W'(1));
    collect("abort");
`ifdef GF_INV_ZERO_FLAG_EN
    chk("zero_err_clr", W'(zero_err), W'(0));
`endif
    issue(rand_elem());
    n = 0;
    while (dut.state != SQ_WAIT && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_sq_wait", W'(dut.state == SQ_WAIT), W'(1));
    rst = 1'b0;
    #1;
    chk("mrst_res", res, '0);
    chk("mrst_finish", W'(finish), W'(0));
    chk("mrst_busy", W'(busy), W'(0));
    @(negedge clk);
    rst = 1'b1;
    start_inv(W'(2));
    collect("post_rst_x");
    for (int i = 0; i < 20; i++) begin
      start_inv(rand_elem());
      collect($sformatf("rand%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gf_inverter.md
GF_INVERTER -- requirements
Module: gf_inverter

Interface
REQ-001 Parameter: DW, default 257, field width; the block is defined only for DW=257 (polynomial x^257+x^12+1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; while high, load operand and hold the block in load state; operation begins on the first cycle start is low.
REQ-005 A  input  DW  field element to invert; sampled on every cycle start is high.
REQ-006 res  output  DW  inverse A^-1 in GF(2^257); valid while finish is high.
REQ-007 finish  output  1  result valid; equals done_r AND NOT start.
REQ-008 busy  output  1  high from the first cycle after start falls until done_r sets.

Function
REQ-009 Inversion SHALL use Itoh-Tsujii: beta_1=A; for k=1,2,4,...,128: beta_2k = (beta_k squared k times) * beta_k; res = beta_256 squared once.
REQ-010 Every squaring and every multiplication SHALL be performed by one shared mod_multiplier instance; a squaring issues the same operand on both inputs.
REQ-011 Operation count per inversion SHALL be 256 squarings plus 8 multiplications.
REQ-012 Multiplier handshake: drive sub-start high for exactly one cycle with operands stable, then wait for sub-finish; capture sub-res on the first cycle sub-finish is high.
REQ-013 Sub-finish SHALL be ignored in the issue cycle and in the cycle after it.
REQ-014 FSM states: IDLE, LOAD, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FIN_ISSUE, FIN_WAIT, DONE.
REQ-015 Transitions: LOAD->SQ_ISSUE when start low; SQ_WAIT->SQ_ISSUE while squarings remain; SQ_WAIT->MUL_ISSUE when k squarings are done; MUL_WAIT->SQ_ISSUE with k doubled if k<128, else ->FIN_ISSUE; FIN_WAIT->DONE.
REQ-016 Counters: k register 8 bits (one-hot or log2 value); squaring-remaining counter 8 bits, loaded with k at the start of each round.
REQ-017 On entering DONE, done_r SHALL set and res SHALL hold the final product until the next start.
REQ-018 A=0 SHALL yield res=0 with normal completion; there is no early exit.
REQ-019 start high in any state SHALL abort the operation, return the FSM to LOAD, clear done_r, and re-issue nothing to the multiplier until start falls.
REQ-020 Latency: finish SHALL assert no more than 11000 cycles after start falls, for any A.

Reset
REQ-021 Asynchronous rst low SHALL force: FSM=IDLE, done_r=0, finish=0, busy=0, res=0, beta/t registers=0, counters=0, sub-start=0.
REQ-022 Reset mid-operation SHALL discard all progress; the multiplier instance SHALL be reset by the same rst.

Configuration
REQ-023 Macro GF_INV_ZERO_FLAG_EN: when defined, add output zero_err (1 bit), set when A=0 is captured in LOAD, cleared by reset or the next start with nonzero A, and valid alongside finish.
REQ-024 Without GF_INV_ZERO_FLAG_EN: the zero_err port and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-025 Package gf257_pkg SHALL hold: DW=257, the reduction tap index 12, the ITOH_ROUNDS=8 constant, and the FSM state enum.
REQ-026 One sub-module: mod_multiplier (existing), instantiated once; no other hierarchy.

Verification
REQ-027 A=1 -> res=1, finish high, busy low.
REQ-028 A=x (bit1 only) -> res has bits 256 and 11 set, all others 0.
REQ-029 A=0 -> res=0; zero_err=1 when GF_INV_ZERO_FLAG_EN is defined.
REQ-030 1000 random nonzero A -> the reference model confirms res*A=1 mod x^257+x^12+1, and latency is 11000 cycles or fewer.
REQ-031 Start re-asserted mid-inversion with new A=1 -> prior work is discarded and res=1.
REQ-032 rst pulsed low during SQ_WAIT -> all outputs 0 immediately, then a clean inversion of A=x on the next start.
